exe_stage: RTL

Execute stage of the five-stage in-order pipeline, between the decode stage and the memory stage. It registers the decoded bundle, computes the ALU result, and issues the data-SRAM request for loads and stores. It also returns destination and result information to decode for hazard detection and forwarding.

---
 rtl/exe_stage_pkg.sv | 31 +++
 rtl/exe_stage_alu.sv | 32 +++
 rtl/exe_stage.sv | 51 +++++
 3 files changed

// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared bus widths, alu_op bit indices and the decode bundle layout.
package exe_stage_pkg;
  localparam int DS_TO_ES_BUS_WD = 150;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_TO_DS_BUS_WD = 39;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_SLT  = 2;
  localparam int OP_SLTU = 3;
  localparam int OP_AND  = 4;
  localparam int OP_NOR  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_XOR  = 7;
  localparam int OP_SLL  = 8;
  localparam int OP_SRL  = 9;
  localparam int OP_SRA  = 10;
  localparam int OP_LUI  = 11;
  typedef struct packed {
    logic [11:0] alu_op;
    logic        res_from_mem;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_bundle_t;
endpackage

// File: rtl/exe_stage_alu.sv
// alu: one-hot opcode ALU; each op result is masked by its select bit and OR-merged.
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);
  logic [31:0] add_r, sub_r, slt_r, sltu_r, sll_r, srl_r, sra_r;
  always_comb begin
    add_r  = src1 + src2;
    sub_r  = src1 - src2;
    slt_r  = {31'd0, $signed(src1) < $signed(src2)};
    sltu_r = {31'd0, src1 < src2};
    sll_r  = src1 << src2[4:0];
    srl_r  = src1 >> src2[4:0];
    sra_r  = $unsigned($signed(src1) >>> src2[4:0]);
    result = ({32{alu_op[OP_ADD]}}  & add_r)
           | ({32{alu_op[OP_SUB]}}  & sub_r)
           | ({32{alu_op[OP_SLT]}}  & slt_r)
           | ({32{alu_op[OP_SLTU]}} & sltu_r)
           | ({32{alu_op[OP_AND]}}  & (src1 & src2))
           | ({32{alu_op[OP_NOR]}}  & ~(src1 | src2))
           | ({32{alu_op[OP_OR]}}   & (src1 | src2))
           | ({32{alu_op[OP_XOR]}}  & (src1 ^ src2))
           | ({32{alu_op[OP_SLL]}}  & sll_r)
           | ({32{alu_op[OP_SRL]}}  & srl_r)
           | ({32{alu_op[OP_SRA]}}  & sra_r)
           | ({32{alu_op[OP_LUI]}}  & src2);
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage; registers the decode bundle, runs the ALU and issues data SRAM requests.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);
  ds_bundle_t  b;
  logic        es_valid;
  logic        fire;
  logic [31:0] src1, src2, alu_result;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      es_valid <= 1'b0;
      b        <= '0;
    end else begin
      if (es_allowin) es_valid <= ds_to_es_valid;
      if (ds_to_es_valid && es_allowin) b <= ds_bundle_t'(ds_to_es_bus);
    end
  end
  assign es_allowin     = !es_valid || ms_allowin;
  assign es_to_ms_valid = es_valid;
  assign src1 = b.src1_is_pc  ? b.pc  : b.rj_value;
  assign src2 = b.src2_is_imm ? b.imm : b.rkd_value;
  alu u_alu (
    .alu_op (b.alu_op),
    .src1   (src1),
    .src2   (src2),
    .result (alu_result)
  );
  // a stalled access is held back so the SRAM never sees a duplicate request
  assign fire            = es_valid && ms_allowin;
  assign data_sram_en    = fire && (b.res_from_mem || b.mem_we);
  assign data_sram_we    = {4{fire && b.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = b.rkd_value;
  assign es_to_ms_bus = {b.res_from_mem, b.gr_we, b.dest, alu_result, b.pc};
  assign es_to_ds_bus = {es_valid && b.res_from_mem, es_valid && b.mem_we,
                         (es_valid && b.gr_we) ? b.dest : 5'd0, alu_result};
endmodule
